md_sequencer: RTL

//  Multi-cycle multiply/divide sequencer beside the E-stage ALU. Accepts one

---
 rtl/md_sequencer.sv | 89 ++++++++
 1 files changed

// File: rtl/md_sequencer.sv
// md_sequencer: multi-cycle mult/multu/div/divu sequencer owning the HI/LO registers.
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-low reset
//   start     in   E-stage md instruction valid
//   md_op     in   0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6-7 none
//   rs_data   in   operand A / mthi-mtlo source
//   rt_data   in   operand B
//   d_md_use  in   D-stage instruction touches HI/LO or the md unit
//   busy      out  operation in progress
//   stall     out  hazard request toward the D stage
//   done      out  one-cycle pulse once HI/LO hold the committed result
//   hi, lo    out  HI/LO registers
module md_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        d_md_use,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);
    typedef enum logic {IDLE, RUN} state_t;
    state_t        state;
    logic [CW-1:0] counter;
    logic [63:0]   res_q;
    logic          wr_q;
    logic          na, nb;
    logic [31:0]   ua, ub, bs, q, r;
    logic [63:0]   res;
    // Division works on magnitudes so 0x80000000 / -1 wraps to 0x80000000
    // naturally and the divider never sees a zero divisor.
    always_comb begin
        na  = ~md_op[0] & rs_data[31];
        nb  = ~md_op[0] & rt_data[31];
        ua  = na ? -rs_data : rs_data;
        ub  = nb ? -rt_data : rt_data;
        bs  = (ub == 32'd0) ? 32'd1 : ub;
        q   = ua / bs;
        r   = ua % bs;
        res = md_op[1] ? {(na ? -r : r), ((na ^ nb) ? -q : q)}
                       : {{32{na}}, rs_data} * {{32{nb}}, rt_data};
    end
    assign stall = d_md_use & (busy | (start & ~md_op[2]));
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            counter <= '0;
            res_q   <= '0;
            wr_q    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start && !md_op[2]) begin
                    res_q   <= res;
                    wr_q    <= !(md_op[1] && rt_data == 32'd0);
                    counter <= md_op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                    busy    <= 1'b1;
                    state   <= RUN;
                end else if (start && md_op == 3'd4) begin
                    hi <= rs_data;
                end else if (start && md_op == 3'd5) begin
                    lo <= rs_data;
                end
            end else begin
                counter <= counter - 1'b1;
                if (counter == CW'(1)) begin
                    if (wr_q) {hi, lo} <= res_q;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
            end
        end
    end
endmodule
